uart_tx_streamer: RTL

Bus-master front end for the UART peripheral: accepts a byte stream on a valid/ready port, buffers it in a small FIFO, and drains it into the UART through the UART's 2-bit-addressed register port. It writes the config register once after reset, then for each byte polls the status register (address 2) until txReady=1 and writes the byte to the data register (address 0). It sits directly upstream of the UART and is its only bus master.

---
 rtl/uart_tx_streamer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_streamer.sv
// Byte-stream front end for the UART: FIFO-buffers incoming bytes and writes
// each one to the UART data register once a status poll reports txReady.
module uart_tx_streamer #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] CONFIG_WORD = 32'h01B2_8000,
    parameter int unsigned TIMEOUT     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  inData,
    input  logic                        inValid,
    output logic                        inReady,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        busy,
    output logic                        uartRead,
    output logic                        uartWrite,
    output logic [1:0]                  uartAddress,
    output logic [31:0]                 uartWriteData,
    input  logic                        uartReadValid,
    input  logic [31:0]                 uartReadData
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] TMO_L   = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        POLL,
        WAIT,
        WRITE,
        COOL
    } state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   waitCnt;
    logic [CW-1:0]   waitNext;
    logic            coolLast;
    logic            push;
    logic            pop;
    logic            unusedBits;

    assign inReady    = (state != INIT) && (level < DEPTH_L);
    assign busy       = (level != '0) || (state != IDLE);
    assign push       = inValid && inReady;
    assign pop        = (state == WRITE);
    assign waitNext   = waitCnt + CW'(1);
    assign unusedBits = ^uartReadData[31:1];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= inData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Outputs are registered alongside the state they belong to, so each
    // strobe is high exactly during the cycle its state is current.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= INIT;
            uartRead      <= 1'b0;
            uartWrite     <= 1'b0;
            uartAddress   <= 2'd0;
            uartWriteData <= 32'd0;
            waitCnt       <= '0;
            coolLast      <= 1'b0;
        end else begin
            uartRead  <= 1'b0;
            uartWrite <= 1'b0;
            unique case (state)
                INIT: begin
                    if (uartWrite) begin
                        state <= IDLE;
                    end else begin
                        uartWrite     <= 1'b1;
                        uartAddress   <= 2'd3;
                        uartWriteData <= CONFIG_WORD;
                    end
                end
                IDLE: begin
                    if (level != '0) begin
                        state       <= POLL;
                        uartRead    <= 1'b1;
                        uartAddress <= 2'd2;
                    end
                end
                POLL: begin
                    state   <= WAIT;
                    waitCnt <= '0;
                end
                WAIT: begin
                    if (uartReadValid && uartReadData[0]) begin
                        state         <= WRITE;
                        uartWrite     <= 1'b1;
                        uartAddress   <= 2'd0;
                        uartWriteData <= {24'd0, mem[head]};
                    end else if (uartReadValid || waitNext == TMO_L) begin
                        state    <= POLL;
                        uartRead <= 1'b1;
                    end else begin
                        waitCnt <= waitNext;
                    end
                end
                WRITE: begin
                    state    <= COOL;
                    coolLast <= 1'b0;
                end
                COOL: begin
                    if (coolLast) begin
                        state <= IDLE;
                    end else begin
                        coolLast <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
